// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store initiator.
//
// Converts the CPU's MemRead/MemWrite/Funct3/addr/wd into a single
// handshaked, word-aligned request with byte enables. It formats load data
// (sign/zero extension), stalls the pipeline while an access is in flight,
// and reports alignment faults and memory timeouts alongside done.
//
// Ports:
//   clk, reset       rising-edge clock; synchronous active-low reset
//   MemRead/MemWrite load/store request (MemRead wins if both are set)
//   Funct3           access size/sign code (instruction bits 14:12)
//   addr, wd         byte address and store data
//   rd               formatted load data, valid with done
//   stall            hold the pipeline
//   done             one-cycle completion pulse
//   misaligned       with done: alignment fault, no memory access made
//   bus_err          with done: memory never answered within TIMEOUT cycles
//   mem_req/mem_we   request valid / write direction to data memory
//   mem_addr         word-aligned byte address
//   mem_be           byte enables
//   mem_wdata        lane-replicated store data
//   mem_ready        memory accepted/completed the request this cycle
//   mem_rdata        read word, valid with mem_ready on a read
module lsu_ctrl #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wd,
    output logic [DATA_W-1:0]     rd,
    output logic                  stall,
    output logic                  done,
    output logic                  misaligned,
    output logic                  bus_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata
);

    // Wide enough to hold TIMEOUT-1 even when TIMEOUT is 1 or a power of two.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       off_q;
    logic [2:0]       f3_q;
    logic             mis_q;
    logic             berr_q;

    logic request;
    logic addr_bad;
    logic timeout_hit;

    // Size for the alignment check comes from Funct3[1:0] only, so the
    // unsigned load codes share the rules of their signed counterparts.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3,
                                            input logic [1:0] off);
        case (f3)
            3'b000:  return 4'b0001 << off;
            3'b001:  return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data is replicated across all lanes; mem_be picks the live ones.
    function automatic logic [DATA_W-1:0] store_data(input logic [2:0]        f3,
                                                     input logic [DATA_W-1:0] w);
        case (f3)
            3'b000:  return {4{w[7:0]}};
            3'b001:  return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_data(input logic [2:0]        f3,
                                                    input logic [1:0]        off,
                                                    input logic [DATA_W-1:0] w);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{(DATA_W-8){b[7]}}, b};
            3'b100:  return {{(DATA_W-8){1'b0}}, b};
            3'b001:  return {{(DATA_W-16){h[15]}}, h};
            3'b101:  return {{(DATA_W-16){1'b0}}, h};
            default: return w;
        endcase
    endfunction

    assign request     = MemRead | MemWrite;
    assign addr_bad    = is_misaligned(Funct3[1:0], addr[1:0]);
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        mem_req    = 1'b0;
        done       = 1'b0;
        misaligned = 1'b0;
        bus_err    = 1'b0;
        case (state)
            IDLE: begin
                // Stall is combinational so the pipeline freezes in the
                // same cycle the request appears.
                stall = request;
                if (request) begin
                    state_next = addr_bad ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ready || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                misaligned = mis_q;
                bus_err    = berr_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            off_q     <= '0;
            f3_q      <= '0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
            rd        <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt    <= '0;
                    mis_q  <= 1'b0;
                    berr_q <= 1'b0;
                    if (request) begin
                        if (addr_bad) begin
                            mis_q <= 1'b1;
                            rd    <= '0;
                        end else begin
                            off_q    <= addr[1:0];
                            f3_q     <= Funct3;
                            mem_we   <= ~MemRead;
                            mem_addr <= {addr[DM_ADDRESS-1:2], 2'b00};
                            if (MemRead) begin
                                mem_be    <= 4'b1111;
                                mem_wdata <= '0;
                            end else begin
                                mem_be    <= store_be(Funct3, addr[1:0]);
                                mem_wdata <= store_data(Funct3, wd);
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (!mem_we) begin
                            rd <= load_data(f3_q, off_q, mem_rdata);
                        end
                    end else if (timeout_hit) begin
                        berr_q <= 1'b1;
                        rd     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    cnt    <= '0;
                    mis_q  <= 1'b0;
                    berr_q <= 1'b0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
`timescale 1ns/1ps
module tb_lsu_ctrl;
    localparam int DM_ADDRESS = 9;
    localparam int DATA_W     = 32;
    localparam int TIMEOUT    = 16;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  MemRead = 1'b0;
    logic                  MemWrite = 1'b0;
    logic [2:0]            Funct3 = '0;
    logic [DM_ADDRESS-1:0] addr = '0;
    logic [DATA_W-1:0]     wd = '0;
    logic [DATA_W-1:0]     rd;
    logic                  stall;
    logic                  done;
    logic                  misaligned;
    logic                  bus_err;
    logic                  mem_req;
    logic                  mem_we;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_ready = 1'b0;
    logic [DATA_W-1:0]     mem_rdata = '0;

    lsu_ctrl #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .addr(addr), .wd(wd), .rd(rd), .stall(stall),
        .done(done), .misaligned(misaligned), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_rd = '0;

    typedef struct {
        int                    latency;
        int                    stall_cycles;
        int                    access_cycles;
        bit                    stall_first;
        bit                    stable;
        bit                    done_after;
        logic [DM_ADDRESS-1:0] addr_seen;
        logic [3:0]            be_seen;
        logic [31:0]           wdata_seen;
        logic                  we_seen;
        logic [31:0]           rd;
        logic                  mis;
        logic                  berr;
    } obs_t;

    // ---------------- reference model (access rules as arithmetic) -------
    function automatic int ld_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int st_size(input logic [2:0] f3);
        if (f3 == 3'b000) return 1;
        if (f3 == 3'b001) return 2;
        return 4;
    endfunction

    function automatic bit exp_mis(input logic [2:0] f3, input logic [8:0] a);
        int off;
        off = int'(a[1:0]);
        return (off % ld_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [8:0] a);
        int n, off, start;
        n = st_size(f3);
        off = int'(a[1:0]);
        start = off - (off % n);
        return 4'(((1 << n) - 1) << start);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        int n;
        n = st_size(f3);
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [8:0] a,
                                             input logic [31:0] word);
        int n, off, start;
        logic [31:0] v, mask;
        n = ld_size(f3);
        off = int'(a[1:0]);
        start = off - (off % n);
        v = word >> (8 * start);
        if (n < 4) begin
            mask = (32'h1 << (8 * n)) - 32'h1;
            v = v & mask;
            if (!f3[2] && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // ---------------- transaction driver (observes, does not judge) ------
    // waits < 0 means mem_ready is never asserted.
    task automatic do_txn(input bit mr, input bit mw, input logic [2:0] f3,
                          input logic [8:0] a, input logic [31:0] w,
                          input logic [31:0] rdata, input int waits, output obs_t o);
        o.latency = -1; o.stall_cycles = 0; o.access_cycles = 0;
        o.stall_first = 0; o.stable = 1; o.done_after = 0;
        o.addr_seen = '0; o.be_seen = '0; o.wdata_seen = '0; o.we_seen = 0;
        o.rd = '0; o.mis = 0; o.berr = 0;
        @(negedge clk);
        MemRead = mr; MemWrite = mw; Funct3 = f3; addr = a; wd = w;
        mem_rdata = rdata; mem_ready = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            #1;
            if (cyc == 0) o.stall_first = stall;
            if (done) begin
                o.latency = cyc; o.rd = rd; o.mis = misaligned; o.berr = bus_err;
                MemRead = 0; MemWrite = 0; mem_ready = 0;
                @(negedge clk); #1;
                o.done_after = done;
                break;
            end
            if (stall) o.stall_cycles++;
            if (mem_req) begin
                if (o.access_cycles == 0) begin
                    o.addr_seen = mem_addr; o.be_seen = mem_be;
                    o.wdata_seen = mem_wdata; o.we_seen = mem_we;
                end else if (mem_addr !== o.addr_seen || mem_be !== o.be_seen ||
                             mem_wdata !== o.wdata_seen || mem_we !== o.we_seen) begin
                    o.stable = 0;
                end
                o.access_cycles++;
                mem_ready = (waits >= 0) && (o.access_cycles > waits);
            end else begin
                mem_ready = 0;
            end
            @(negedge clk);
        end
        MemRead = 0; MemWrite = 0; mem_ready = 0;
    endtask

    // ---------------- tests ----------------------------------------------
    task automatic test_reset();
        reset = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({rd, stall, done, misaligned, bus_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%h stall=%b done=%b req=%b we=%b addr=%h be=%b wdata=%h, required all zero",
                     rd, stall, done, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
        end
        reset = 1;
        model_rd = '0;
    endtask

    task automatic test_store_word();
        obs_t o;
        do_txn(0, 1, 3'b010, 9'h044, 32'hDEADBEEF, 32'h0, 0, o);
        checks++; if (o.addr_seen !== 9'h044) begin errors++; $display("FAIL sw_addr: got %h want 044", o.addr_seen); end
        checks++; if (o.be_seen !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b want 1111", o.be_seen); end
        checks++; if (o.wdata_seen !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h want deadbeef", o.wdata_seen); end
        checks++; if (o.we_seen !== 1'b1) begin errors++; $display("FAIL sw_we: got %b want 1", o.we_seen); end
        checks++; if (o.stall_first !== 1'b1) begin errors++; $display("FAIL sw_stall_comb: got %b want 1", o.stall_first); end
        checks++; if (o.stall_cycles != 2) begin errors++; $display("FAIL sw_stall_cycles: got %0d want 2", o.stall_cycles); end
        checks++; if (o.latency != 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", o.latency); end
        checks++; if (o.done_after !== 1'b0) begin errors++; $display("FAIL sw_done_pulse: done still %b next cycle, want 0", o.done_after); end
        checks++; if (o.rd !== model_rd) begin errors++; $display("FAIL sw_rd_hold: got %h want %h", o.rd, model_rd); end
    endtask

    task automatic test_store_lanes();
        obs_t o;
        do_txn(0, 1, 3'b000, 9'h013, 32'h000000A5, 32'h0, 0, o);
        checks++; if (o.be_seen !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b want 1000", o.be_seen); end
        checks++; if (o.wdata_seen !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata: got %h want a5a5a5a5", o.wdata_seen); end
        checks++; if (o.addr_seen !== 9'h010) begin errors++; $display("FAIL sb_addr: got %h want 010", o.addr_seen); end
        do_txn(0, 1, 3'b001, 9'h012, 32'h00001234, 32'h0, 0, o);
        checks++; if (o.be_seen !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b want 1100", o.be_seen); end
        checks++; if (o.wdata_seen !== 32'h12341234) begin errors++; $display("FAIL sh_wdata: got %h want 12341234", o.wdata_seen); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [8:0]  adrs [5] = '{9'h022, 9'h022, 9'h022, 9'h020, 9'h020};
        logic [31:0] exps [5] = '{32'hFFFFFFF1, 32'h000000F1, 32'hFFFF80F1, 32'h00007F01, 32'h80F17F01};
        obs_t o;
        for (int i = 0; i < 5; i++) begin
            do_txn(1, 0, f3s[i], adrs[i], 32'h0, 32'h80F17F01, 0, o);
            checks++;
            if (o.rd !== exps[i] || o.latency != 2) begin
                errors++;
                $display("FAIL load_%0d: rd=%h latency=%0d, want rd=%h latency=2", i, o.rd, o.latency, exps[i]);
            end
            checks++;
            if (o.be_seen !== 4'b1111 || o.we_seen !== 1'b0) begin
                errors++;
                $display("FAIL load_%0d_bus: be=%b we=%b, want be=1111 we=0", i, o.be_seen, o.we_seen);
            end
        end
        model_rd = 32'h80F17F01;
    endtask

    task automatic test_misaligned();
        obs_t o;
        do_txn(1, 0, 3'b010, 9'h006, 32'h0, 32'h5555AAAA, 0, o);
        checks++;
        if (o.access_cycles != 0 || o.latency != 1 || o.mis !== 1'b1 || o.rd !== 32'h0 || o.berr !== 1'b0) begin
            errors++;
            $display("FAIL mis_lw: req_cycles=%0d latency=%0d mis=%b berr=%b rd=%h, want 0/1/1/0/0",
                     o.access_cycles, o.latency, o.mis, o.berr, o.rd);
        end
        do_txn(0, 1, 3'b001, 9'h011, 32'hFFFF, 32'h0, 0, o);
        checks++;
        if (o.access_cycles != 0 || o.latency != 1 || o.mis !== 1'b1 || o.rd !== 32'h0) begin
            errors++;
            $display("FAIL mis_sh: req_cycles=%0d latency=%0d mis=%b rd=%h, want 0/1/1/0",
                     o.access_cycles, o.latency, o.mis, o.rd);
        end
        model_rd = '0;
    endtask

    task automatic test_wait_states();
        obs_t o;
        do_txn(1, 0, 3'b101, 9'h0F2, 32'h0, 32'hBEEF1234, 3, o);
        checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL wait_stable: mem_* changed during ACCESS"); end
        checks++; if (o.access_cycles != 4 || o.stall_cycles != 5) begin errors++; $display("FAIL wait_cycles: access=%0d stall=%0d, want 4/5", o.access_cycles, o.stall_cycles); end
        checks++; if (o.latency != 5 || o.rd !== 32'h0000BEEF) begin errors++; $display("FAIL wait_result: latency=%0d rd=%h, want 5/0000beef", o.latency, o.rd); end
        model_rd = 32'h0000BEEF;
    endtask

    task automatic test_timeout();
        obs_t o;
        do_txn(1, 0, 3'b010, 9'h100, 32'h0, 32'h11111111, -1, o);
        checks++; if (o.access_cycles != TIMEOUT) begin errors++; $display("FAIL timeout_cycles: got %0d want %0d", o.access_cycles, TIMEOUT); end
        checks++;
        if (o.latency != TIMEOUT + 1 || o.berr !== 1'b1 || o.mis !== 1'b0 || o.rd !== 32'h0) begin
            errors++;
            $display("FAIL timeout_result: latency=%0d berr=%b mis=%b rd=%h, want %0d/1/0/0", o.latency, o.berr, o.mis, o.rd, TIMEOUT + 1);
        end
        checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL timeout_stable: mem_* changed during ACCESS"); end
        model_rd = '0;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        do_txn(1, 0, 3'b010, 9'h030, 32'h0, 32'h12345678, 0, o);
        checks++; if (o.rd !== 32'h12345678) begin errors++; $display("FAIL premid_rd: got %h want 12345678", o.rd); end
        @(negedge clk);
        MemWrite = 1; Funct3 = 3'b010; addr = 9'h024; wd = 32'hCAFEF00D; mem_ready = 0;
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_in_access: mem_req=%b want 1", mem_req); end
        reset = 0; MemWrite = 0;
        @(negedge clk); #1;
        checks++;
        if ({rd, stall, done, misaligned, bus_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: rd=%h stall=%b req=%b we=%b addr=%h be=%b wdata=%h, required all zero",
                     rd, stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
        end
        reset = 1;
        model_rd = '0;
        do_txn(1, 0, 3'b010, 9'h034, 32'h0, 32'h0BADF00D, 0, o);
        checks++;
        if (o.rd !== 32'h0BADF00D || o.latency != 2) begin
            errors++;
            $display("FAIL post_reset_lw: rd=%h latency=%0d, want 0badf00d/2", o.rd, o.latency);
        end
        model_rd = 32'h0BADF00D;
    endtask

    task automatic test_random();
        obs_t o;
        bit mr, mw, mis;
        logic [2:0]  f3;
        logic [8:0]  a;
        logic [31:0] w, word, erd;
        int waits, kind;
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 2);
            mr = (kind != 1);
            mw = (kind != 0);
            f3 = 3'($urandom);
            a = 9'($urandom);
            w = $urandom;
            word = $urandom;
            waits = $urandom_range(0, 3);
            do_txn(mr, mw, f3, a, w, word, waits, o);
            mis = exp_mis(f3, a);
            if (mis) erd = '0;
            else if (mr) erd = exp_load(f3, a, word);
            else erd = model_rd;
            checks++;
            if (o.mis !== mis || o.berr !== 1'b0 || o.rd !== erd ||
                o.latency != (mis ? 1 : waits + 2) || o.done_after !== 1'b0) begin
                errors++;
                $display("FAIL rand_%0d_result: f3=%b a=%h mis=%b berr=%b rd=%h lat=%0d, want mis=%b rd=%h lat=%0d",
                         t, f3, a, o.mis, o.berr, o.rd, o.latency, mis, erd, mis ? 1 : waits + 2);
            end
            if (!mis) begin
                checks++;
                if (o.addr_seen !== {a[8:2], 2'b00} || o.we_seen !== !mr || o.stable !== 1'b1 ||
                    o.be_seen !== (mr ? 4'b1111 : exp_be(f3, a)) ||
                    (!mr && o.wdata_seen !== exp_wdata(f3, w))) begin
                    errors++;
                    $display("FAIL rand_%0d_bus: f3=%b a=%h addr=%h we=%b be=%b wdata=%h stable=%b",
                             t, f3, a, o.addr_seen, o.we_seen, o.be_seen, o.wdata_seen, o.stable);
                end
            end
            model_rd = erd;
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_lanes();
        test_loads();
        test_misaligned();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator in the MEM stage. Turns the CPU's MemRead/MemWrite/Funct3/address/write-data into handshaked word-aligned requests with byte enables to the data-memory responder.
- Extracts and sign- or zero-extends load data, stalls the pipeline while an access is outstanding, and flags misaligned and timed-out accesses.

Parameters:
- DM_ADDRESS, 9, byte-address width presented to data memory.
- DATA_W, 32, data width (fixed to 32; 4 byte lanes).
- TIMEOUT, 16, max cycles in ACCESS waiting for mem_ready before bus error; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- MemRead  in  1  load request from control unit.
- MemWrite  in  1  store request from control unit.
- Funct3  in  3  instruction bits 14:12.
- addr  in  DM_ADDRESS  byte address (ALU result LSBs).
- wd  in  DATA_W  store data (rs2).
- rd  out  DATA_W  formatted load data; valid when done=1.
- stall  out  1  hold pipeline.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  with done: alignment fault.
- bus_err  out  1  with done: memory timeout.
- mem_req  out  1  request valid to memory.
- mem_we  out  1  1 = write.
- mem_addr  out  DM_ADDRESS  word-aligned address, {addr[DM_ADDRESS-1:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_ready  in  1  memory accepted/completed request this cycle.
- mem_rdata  in  DATA_W  read word; valid when mem_ready=1 and mem_we=0.

Behaviour:
- Reset (reset=0 at clk edge): state IDLE, timeout counter 0, latched request cleared. All outputs 0, including rd, mem_be and mem_wdata. Reset mid-ACCESS abandons the transaction and drops mem_req the next cycle.
- States: IDLE, ACCESS, DONE.
- IDLE: a request is MemRead|MemWrite; if both are set, MemRead has priority. stall = request, combinational, same cycle.
  - Aligned request: at the edge, latch addr[1:0], Funct3, direction, mem_addr, mem_be and mem_wdata; go to ACCESS.
  - Misaligned request: go to DONE with misaligned=1 and no memory access. Misaligned means half (Funct3[1:0]=01) with addr[0]=1, or word (Funct3[1:0]=10 or 11) with addr[1:0]!=0.
- ACCESS: mem_req=1 and stall=1; mem_* outputs hold stable until mem_ready.
  - On mem_ready: for loads, register the formatted rd; go to DONE.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without mem_ready: go to DONE with bus_err=1 and rd=0; mem_req drops.
- DONE: done=1, stall=0, mem_req=0 for exactly one cycle; rd, misaligned and bus_err are valid only here. Inputs seen in DONE belong to the retiring instruction and are ignored. Always return to IDLE; the counter clears.
- Minimum latency for a zero-wait memory: request cycle, ACCESS cycle with mem_ready, then done. That is 2 stalled cycles plus the done cycle.
- Store formatting, with off = addr[1:0]:
  - SB (000): mem_be = 1<<off; mem_wdata = {4{wd[7:0]}}.
  - SH (001): mem_be = off[1] ? 1100 : 0011; mem_wdata = {2{wd[15:0]}}.
  - SW and any other Funct3: mem_be = 1111; mem_wdata = wd.
- Load formatting uses the latched off; mem_be = 1111 for all reads.
  - LB (000): mem_rdata byte[off], sign-extended.
  - LBU (100): same byte, zero-extended.
  - LH (001): half[off[1]], sign-extended.
  - LHU (101): same half, zero-extended.
  - LW (010) and other codes: full word.
- rd holds its last value outside DONE. Error completions write rd=0.

Test Plan:
- SW: MemWrite=1, Funct3=010, addr=0x044, wd=0xDEADBEEF, mem_ready=1 in first ACCESS cycle -> mem_addr=0x044, mem_be=1111, mem_wdata=0xDEADBEEF, mem_we=1; stall high 2 cycles, then done=1.
- SB/SH lanes: SB addr=0x013, wd=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x010. SH addr=0x012, wd=0x1234 -> mem_be=1100, mem_wdata=0x12341234.
- Loads with mem_rdata=0x80F17F01:
  - LB off=2 -> 0xFFFFFFF1.
  - LBU off=2 -> 0x000000F1.
  - LH off=2 -> 0xFFFF80F1.
  - LHU off=0 -> 0x00007F01.
  - LW -> 0x80F17F01.
- Misaligned: LW addr=0x006 and SH addr=0x011 -> mem_req never asserted; next cycle done=1, misaligned=1, rd=0.
- Wait states and timeout:
  - mem_ready after 3 wait cycles -> mem_* stable throughout, stall=1, done on the cycle after mem_ready.
  - mem_ready never asserted, TIMEOUT=16 -> 16 ACCESS cycles, then done=1, bus_err=1.
- Reset mid-ACCESS: reset=0 for one edge during ACCESS -> next cycle mem_req=0, stall=0, all outputs 0, state IDLE. A fresh LW afterwards completes normally.
